bus_arbiter: RTL and testbench

- Shares the single CPU-style parallel bus (mreq_n/iorq_n/rd_n/wr_n/addr/data/buswait_n) between NUM_MASTERS bus masters, e.g. cpu plus DMA/debug engines.
- Implements the busrq_n/busack_n handshake per master with round-robin arbitration and an optional tenure limit.
- Multiplexes the owner's address, control and write data onto the shared bus and routes buswait_n back to it.
- Sits between the masters and the address decode that feeds mem/io slaves.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/rr_picker.sv | 29 ++
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the parallel-bus arbiter.
// Holds the arbiter FSM encoding and default bus word types.
package bus_pkg;

    localparam int BUS_DATA_W  = 8;
    localparam int BUS_ADDR_W  = 16;

    // Dead cycles inserted between two tenures.
    localparam int TURN_CYCLES = 1;

    typedef logic [BUS_DATA_W-1:0] bus_data_t;
    typedef logic [BUS_ADDR_W-1:0] bus_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        REVOKE,
        TURN
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority encoder: picks the first requester
// after the last owner, wrapping around.
module rr_picker #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] sel_o,
    output logic         valid_o
);

    logic [W-1:0] idx;

    // Scan from last+1 upwards; the first hit wins.
    always_comb begin
        sel_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                sel_o   = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared CPU-style bus with an
// optional tenure limit and a dead cycle between owners.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int MAX_TENURE  = 64,
    parameter int OWNER_W     = $clog2(NUM_MASTERS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                busrq_n,
    output logic [NUM_MASTERS-1:0]                busack_n,
    input  logic [NUM_MASTERS-1:0]                m_mreq_n,
    input  logic [NUM_MASTERS-1:0]                m_iorq_n,
    input  logic [NUM_MASTERS-1:0]                m_rd_n,
    input  logic [NUM_MASTERS-1:0]                m_wr_n,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]                m_buswait_n,
    output logic                                  mreq_n,
    output logic                                  iorq_n,
    output logic                                  rd_n,
    output logic                                  wr_n,
    output logic [ADDR_WIDTH-1:0]                 addr,
    output logic [DATA_WIDTH-1:0]                 wdata,
    output logic                                  wdata_oe,
    input  logic                                  buswait_n,
    output logic [OWNER_W-1:0]                    owner,
    output logic                                  owner_valid
);

    localparam int TEN_W =
        (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
    localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE);

    localparam int TURN_W = $clog2(TURN_CYCLES + 1);
    localparam logic [TURN_W-1:0] TURN_LAST =
        TURN_W'(TURN_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  last_q, last_d;
    logic [TEN_W-1:0]    ten_q, ten_d;
    logic [TURN_W-1:0]   turn_q, turn_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] own_onehot;
    logic [OWNER_W-1:0]     pick_sel;
    logic                   pick_valid;
    logic                   own_idle;
    logic                   cyc;
    logic                   others_wait;
    logic                   rel_done;
    logic                   ten_full;
    logic                   revoke_go;

    assign req        = ~busrq_n;
    assign own_onehot = NUM_MASTERS'(1) << owner_q;

    rr_picker #(
        .N (NUM_MASTERS),
        .W (OWNER_W)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .sel_o   (pick_sel),
        .valid_o (pick_valid)
    );

    // A bus cycle is in flight while any owner strobe or the
    // slave wait is asserted; ownership cannot move mid-cycle.
    assign own_idle = m_mreq_n[owner_q] & m_iorq_n[owner_q]
                    & m_rd_n[owner_q] & m_wr_n[owner_q];
    assign cyc      = ~own_idle | ~buswait_n;

    assign others_wait = |(req & ~own_onehot);
    assign rel_done    = busrq_n[owner_q] & ~cyc;
    assign ten_full    = (MAX_TENURE != 0) && (ten_q >= TEN_MAX);
    assign revoke_go   = (state_q == GRANT) & ~rel_done
                       & ten_full & others_wait;

    // State, owner, round-robin pointer and tenure registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWNER_W'(NUM_MASTERS - 1);
            ten_q   <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ten_q   <= ten_d;
            turn_q  <= turn_d;
        end
    end

    // Next-state logic: arbitrate, hold, revoke, turn around.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        ten_d   = ten_q;
        turn_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_sel;
                    ten_d   = '0;
                end
            end
            GRANT: begin
                if (ten_q != TEN_MAX) begin
                    ten_d = ten_q + 1'b1;
                end
                if (rel_done) begin
                    state_d = TURN;
                end else if (revoke_go) begin
                    state_d = REVOKE;
                end
            end
            REVOKE: begin
                if (!cyc) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                last_d = owner_q;
                turn_d = turn_q + 1'b1;
                if (turn_q == TURN_LAST) begin
                    state_d = IDLE;
                    turn_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: owner pass-through, quiet bus otherwise.
    always_comb begin
        busack_n    = '1;
        m_buswait_n = '0;
        mreq_n      = 1'b1;
        iorq_n      = 1'b1;
        rd_n        = 1'b1;
        wr_n        = 1'b1;
        addr        = '0;
        wdata       = '0;
        wdata_oe    = 1'b0;
        owner_valid = (state_q == GRANT) || (state_q == REVOKE);
        if (owner_valid) begin
            mreq_n   = m_mreq_n[owner_q];
            iorq_n   = m_iorq_n[owner_q];
            rd_n     = m_rd_n[owner_q];
            wr_n     = m_wr_n[owner_q];
            addr     = m_addr[owner_q];
            wdata    = m_wdata[owner_q];
            wdata_oe = ~m_wr_n[owner_q];
            m_buswait_n[owner_q] = buswait_n;
        end
        if ((state_q == GRANT) && !revoke_go) begin
            busack_n[owner_q] = 1'b0;
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter (4 masters, tenure 8)
// against a cycle-level reference model of the arbitration rules.
module tb_bus_arbiter;

    localparam int N    = 4;
    localparam int MAXT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     busrq_n, busack_n;
    logic [N-1:0]     m_mreq_n, m_iorq_n, m_rd_n, m_wr_n;
    logic [N-1:0][15:0] m_addr;
    logic [N-1:0][7:0]  m_wdata;
    logic [N-1:0]     m_buswait_n;
    logic             mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0]      addr;
    logic [7:0]       wdata;
    logic             wdata_oe;
    logic             buswait_n;
    logic [1:0]       owner;
    logic             owner_valid;

    int total = 0;
    int bad   = 0;

    // reference model: owner (-1 = none), revoking flag,
    // dead-cycle flag, last owner, cycles held
    int mo, mlast, mten;
    bit mrev, mturn;
    bit s_cyc, s_rel, s_rev;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (16),
        .MAX_TENURE  (MAXT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .busrq_n     (busrq_n),
        .busack_n    (busack_n),
        .m_mreq_n    (m_mreq_n),
        .m_iorq_n    (m_iorq_n),
        .m_rd_n      (m_rd_n),
        .m_wr_n      (m_wr_n),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_buswait_n (m_buswait_n),
        .mreq_n      (mreq_n),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .addr        (addr),
        .wdata       (wdata),
        .wdata_oe    (wdata_oe),
        .buswait_n   (buswait_n),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare all outputs with the model (1ns after the negedge).
    task automatic look();
        logic [3:0]  eack, estr, ebw;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        eoe;
        bit          g, cyc, oth;
        #1;
        g = (mo >= 0);
        cyc = 0; oth = 0; s_rel = 0; s_rev = 0;
        eack = '1; estr = '1; ebw = '0; ea = '0; ed = '0; eoe = 0;
        for (int j = 0; j < N; j++)
            if (j != mo && !busrq_n[j]) oth = 1;
        if (g) begin
            cyc = !m_mreq_n[mo] || !m_iorq_n[mo] || !m_rd_n[mo]
               || !m_wr_n[mo] || !buswait_n;
            s_rel = !mrev && busrq_n[mo] && !cyc;
            s_rev = !mrev && !s_rel && (mten >= MAXT) && oth;
            if (!mrev && !s_rev) eack[mo] = 1'b0;
            estr = {m_mreq_n[mo], m_iorq_n[mo], m_rd_n[mo], m_wr_n[mo]};
            ea = m_addr[mo];
            ed = m_wdata[mo];
            eoe = !m_wr_n[mo];
            ebw[mo] = buswait_n;
        end
        s_cyc = cyc;
        chk("busack_n", busack_n, eack);
        chk("owner_valid", owner_valid, g);
        if (g) chk("owner", owner, mo);
        chk("strobes", {mreq_n, iorq_n, rd_n, wr_n}, estr);
        chk("addr", addr, ea);
        chk("wdata", wdata, ed);
        chk("wdata_oe", wdata_oe, eoe);
        chk("m_buswait_n", m_buswait_n, ebw);
    endtask

    // Advance the model across one rising edge.
    task automatic adv();
        @(posedge clk);
        if (reset) begin
            mo = -1; mrev = 0; mturn = 0; mlast = N - 1; mten = 0;
        end else if (mo >= 0) begin
            if (mrev ? !s_cyc : s_rel) begin
                mlast = mo; mo = -1; mturn = 1;
            end else if (s_rev) begin
                mrev = 1;
            end else if (mten < MAXT) begin
                mten++;
            end
        end else if (mturn) begin
            mturn = 0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int j = (mlast + k) % N;
                if (mo < 0 && !busrq_n[j]) begin
                    mo = j; mten = 0; mrev = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        busrq_n = '1;
        adv();
        adv();
        reset = 1'b0;
    endtask

    initial begin
        int held[N];
        int order[$];
        int gaps[$];
        int quiet, lo0, q2;
        bit pv, got1;

        mo = -1; mrev = 0; mturn = 0; mlast = N - 1; mten = 0;
        reset = 1'b1; busrq_n = '1;
        m_mreq_n = '1; m_iorq_n = '1; m_rd_n = '1; m_wr_n = '1;
        m_addr = '0; m_wdata = '0; buswait_n = 1'b1;
        do_reset();

        // reset state
        reset = 1'b1;
        look();
        chk("rst_owner", owner, 0);
        chk("rst_ack", busack_n, 4'hF);
        adv();
        reset = 1'b0;

        // single request, 1-cycle grant latency
        m_addr[0] = 16'h1234;
        busrq_n = 4'b1110;
        look();
        chk("pre_grant_ack", busack_n, 4'hF);
        adv();
        look();
        chk("grant_ack", busack_n, 4'b1110);
        chk("grant_addr", addr, 16'h1234);
        adv();

        // alternating tenures of masters 0 and 1
        do_reset();
        held = '{default: 0};
        quiet = 0; pv = 0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 2; i++) busrq_n[i] = (held[i] >= 4);
            look();
            if (owner_valid && !pv) begin
                order.push_back(int'(owner));
                gaps.push_back(quiet);
            end
            quiet = owner_valid ? 0 : quiet + 1;
            pv = owner_valid;
            for (int i = 0; i < 2; i++)
                held[i] = busack_n[i] ? 0 : held[i] + 1;
            adv();
        end
        chk("alt_count", order.size() >= 4, 1);
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            chk("alt_order", order[k], k % 2);
            if (k > 0) chk("alt_gap", gaps[k], 2);
        end

        // release held off by an active read with wait
        do_reset();
        busrq_n = 4'b1110;
        look();
        adv();
        m_rd_n[0] = 1'b0;
        buswait_n = 1'b0;
        busrq_n[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            look();
            chk("hold_ack", busack_n[0], 0);
            adv();
        end
        buswait_n = 1'b1;
        m_rd_n[0] = 1'b1;
        look();
        chk("hold_last_ack", busack_n[0], 0);
        adv();
        look();
        chk("turn_ack", busack_n, 4'hF);
        chk("turn_valid", owner_valid, 0);
        adv();
        look();
        adv();

        // tenure revocation
        do_reset();
        busrq_n = 4'b1110;
        lo0 = 0; q2 = 0; got1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) busrq_n[1] = 1'b0;
            look();
            if (!busack_n[0]) lo0++;
            if (lo0 > 0 && !owner_valid) q2++;
            if (!busack_n[1]) begin
                got1 = 1;
                break;
            end
            adv();
        end
        chk("rev_granted1", got1, 1);
        chk("rev_len", lo0, MAXT);
        chk("rev_quiet", q2, 2);
        chk("rev_ack", busack_n, 4'b1101);
        adv();

        // reset in the middle of a write by master 1
        m_wr_n[1] = 1'b0;
        m_wdata[1] = 8'hA5;
        m_addr[1] = 16'hBEEF;
        look();
        chk("wr_oe", wdata_oe, 1);
        chk("wr_data", wdata, 8'hA5);
        reset = 1'b1;
        adv();
        look();
        chk("mid_rst_ack", busack_n, 4'hF);
        chk("mid_rst_wr", wr_n, 1);
        chk("mid_rst_oe", wdata_oe, 0);
        chk("mid_rst_valid", owner_valid, 0);
        m_wr_n[1] = 1'b1;
        adv();
        reset = 1'b0;

        // all four request together
        do_reset();
        held = '{default: 0};
        order.delete();
        pv = 0;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++) begin
                busrq_n[i] = (held[i] >= 2);
                m_wr_n[i] = ($urandom_range(0, 2) != 0);
                m_wdata[i] = 8'($urandom);
            end
            look();
            if (owner_valid && !pv) order.push_back(int'(owner));
            pv = owner_valid;
            for (int i = 0; i < N; i++)
                held[i] = busack_n[i] ? 0 : held[i] + 1;
            adv();
        end
        m_wr_n = '1;
        chk("rr4_count", order.size() >= 5, 1);
        for (int k = 0; k < 5 && k < order.size(); k++)
            chk("rr4_order", order[k], k % N);

        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) busrq_n[i] = ~busrq_n[i];
                m_mreq_n[i] = ($urandom_range(0, 7) != 0);
                m_iorq_n[i] = ($urandom_range(0, 7) != 0);
                m_rd_n[i]   = ($urandom_range(0, 7) != 0);
                m_wr_n[i]   = ($urandom_range(0, 7) != 0);
                m_addr[i]   = 16'($urandom);
                m_wdata[i]  = 8'($urandom);
            end
            buswait_n = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 127) == 0);
            look();
            adv();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
